rst_sequencer: RTL

- Parametrised successor to the single-output power-on reset generator.
- Sequences NUM_CH active-low reset domains in a fixed staggered order after three conditions are met: the power-on hold time expires, a PLL lock is stable, and each inter-stage delay elapses.
- Re-asserts every domain on PLL lock loss or on a soft reset request.
- Sits at the top of the design between the raw board clock, the PLL and all downstream logic.

---
 rtl/rst_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staggered multi-domain reset sequencer qualified by power-on hold and PLL lock (optional watchdog: RST_SEQ_WDT_EN)
module rst_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int INIT_CYCLES  = 65535,
    parameter int LOCK_FILT    = 16,
    parameter int STAGE_CYCLES = 1024,
    parameter int MIN_ASSERT   = 256,
    parameter int CNT_W        = 16
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int WDT_CYCLES   = 1 << 20
`endif
) (
    input  logic              clk_50,
    input  logic              por_reset_n,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
`ifdef RST_SEQ_WDT_EN
    input  logic              wdt_kick,
    output logic              wdt_fired,
`endif
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              all_released,
    output logic [2:0]        seq_state,
    output logic [7:0]        fault_cnt
);

    localparam int MAX_A     = (INIT_CYCLES > LOCK_FILT) ? INIT_CYCLES : LOCK_FILT;
    localparam int MAX_B     = (STAGE_CYCLES > MIN_ASSERT) ? STAGE_CYCLES : MIN_ASSERT;
    localparam int MAX_DELAY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] INIT_TERM   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILT_TERM   = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] STAGE_TERM  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASSERT_TERM = CNT_W'(MIN_ASSERT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CH - 1);

    if ($clog2(MAX_DELAY) > CNT_W) begin : g_cnt_w_too_small
        $error("rst_sequencer: CNT_W too narrow for the largest delay parameter");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_num_ch_range
        $error("rst_sequencer: NUM_CH must be 1..16");
    end

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_ASSERT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  rst_n_out_q, rst_n_out_d;
    logic               all_released_q, all_released_d;
    logic [7:0]         fault_cnt_q, fault_cnt_d;
    logic               lock_meta_q, lock_meta_d;
    logic               lock_s_q, lock_s_d;
    logic               abort;
`ifdef RST_SEQ_WDT_EN
    localparam logic [23:0] WDT_TERM = 24'(WDT_CYCLES - 1);
    logic [23:0]        wdt_cnt_q, wdt_cnt_d;
    logic               wdt_fired_q, wdt_fired_d;
    logic               wdt_trip;
`endif

    // Two-flop synchroniser inputs for the asynchronous PLL lock.
    always_comb begin
        lock_meta_d = pll_locked;
        lock_s_d    = lock_meta_q;
    end

    // Lock synchroniser registers.
    always_ff @(posedge clk_50 or negedge por_reset_n) begin
        if (!por_reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
        end
    end

    // Sequencer next-state: one shared counter serves hold, lock filter, stage and assert delays.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        rst_n_out_d    = rst_n_out_q;
        all_released_d = all_released_q;
        fault_cnt_d    = fault_cnt_q;
        abort          = !lock_s_q || soft_rst_req;
`ifdef RST_SEQ_WDT_EN
        wdt_cnt_d   = '0;
        wdt_trip    = (state_q == ST_RUN) && !wdt_kick && (wdt_cnt_q == WDT_TERM);
        wdt_fired_d = wdt_fired_q | wdt_trip;
        abort       = abort || wdt_trip;
`endif
        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == INIT_TERM) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_TERM) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (abort) begin
                    // Fault beats a stage release on the same edge; lock loss counts once even with a soft request.
                    state_d        = ST_ASSERT;
                    cnt_d          = '0;
                    idx_d          = '0;
                    rst_n_out_d    = '0;
                    all_released_d = 1'b0;
                    if (!lock_s_q && fault_cnt_q != 8'hFF) begin
                        fault_cnt_d = fault_cnt_q + 8'd1;
                    end
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == STAGE_TERM) begin
                        cnt_d              = '0;
                        rst_n_out_d[idx_q] = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d        = ST_RUN;
                            all_released_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
`ifdef RST_SEQ_WDT_EN
                    wdt_cnt_d = wdt_kick ? 24'd0 : wdt_cnt_q + 24'd1;
`endif
                end
            end
            ST_ASSERT: begin
                if (cnt_q == ASSERT_TERM) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_50 or negedge por_reset_n) begin
        if (!por_reset_n) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            idx_q          <= '0;
            rst_n_out_q    <= '0;
            all_released_q <= 1'b0;
            fault_cnt_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            rst_n_out_q    <= rst_n_out_d;
            all_released_q <= all_released_d;
            fault_cnt_q    <= fault_cnt_d;
        end
    end

`ifdef RST_SEQ_WDT_EN
    // Watchdog counter and sticky fired flag.
    always_ff @(posedge clk_50 or negedge por_reset_n) begin
        if (!por_reset_n) begin
            wdt_cnt_q   <= 24'd0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign wdt_fired = wdt_fired_q;
`endif

    assign rst_n_out    = rst_n_out_q;
    assign all_released = all_released_q;
    assign seq_state    = state_q;
    assign fault_cnt    = fault_cnt_q;

endmodule
